// File: rtl/vector_checker_pkg.sv
// vector_checker_pkg
//   Shared types and constants for the vector_checker slice: the FSM state
//   encoding, vector/index/error-count widths, the settle timer width and the
//   reference truth table of sillyfunction (y = ~b&~c | a&~b).
package vector_checker_pkg;

  localparam int NUM_VECTORS = 8;
  localparam int IDX_W       = 3;
  localparam int ERR_W       = 4;
  localparam int TIMER_W     = 4;

  // Bit i is y for {a,b,c} == i.
  localparam logic [NUM_VECTORS-1:0] SILLY_EXPECTED = 8'b0011_0001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/settle_timer.sv
// settle_timer
//   Loadable down-counter. A load pulse presets the count to LOAD_VALUE; the
//   count then decrements once per cycle and parks at zero.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset
//   load   in   preset the count to LOAD_VALUE on the next edge
//   tc     out  terminal count, high while the count is zero
module settle_timer #(
  parameter int unsigned      WIDTH      = 4,
  parameter logic [WIDTH-1:0] LOAD_VALUE = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VALUE;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/vector_checker.sv
// vector_checker
//   Hardware stimulus/response checker for a 3-input, 1-output function.
//   Sweeps {a,b,c} through all 8 vectors, holds each for SETTLE_CYCLES cycles
//   plus one check cycle, compares y_in against EXPECTED and accumulates an
//   error count and per-vector fail mask.
//   Optional build macro VECTOR_CHECKER_STOP_ON_FAIL_EN: when defined, the
//   first mismatching vector ends the sweep and a/b/c hold that vector.
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   start      in   single-cycle sweep request (honoured in IDLE/DONE only)
//   y_in       in   output of the function under check
//   a, b, c    out  function inputs, {a,b,c} = current vector index
//   busy       out  sweep in progress
//   done       out  sweep finished, held until the next accepted start
//   pass       out  done with no mismatches
//   err_count  out  number of mismatching vectors (0..8)
//   fail_mask  out  bit i set if vector i mismatched
//
// State  | meaning
// IDLE   | after reset, waiting for start
// SETTLE | vector applied, waiting SETTLE_CYCLES for the function to settle
// CHECK  | y_in sampled against EXPECTED[index] on the closing edge
// DONE   | results held, start re-arms a new sweep
module vector_checker
  import vector_checker_pkg::*;
#(
  parameter logic [NUM_VECTORS-1:0] EXPECTED      = SILLY_EXPECTED,
  parameter int unsigned            SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   y_in,
  output logic                   a,
  output logic                   b,
  output logic                   c,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ERR_W-1:0]       err_count,
  output logic [NUM_VECTORS-1:0] fail_mask
);

  state_t           state;
  logic [IDX_W-1:0] index;
  logic             accept;
  logic             last_vec;
  logic             mismatch;
  logic             finish;
  logic             timer_load;
  logic             timer_tc;
  logic [ERR_W-1:0] err_next;

  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign last_vec = (index == IDX_W'(NUM_VECTORS - 1));
  assign mismatch = (y_in != EXPECTED[index]);
  assign err_next = err_count + {{(ERR_W-1){1'b0}}, mismatch};

`ifdef VECTOR_CHECKER_STOP_ON_FAIL_EN
  assign finish = last_vec || mismatch;
`else
  assign finish = last_vec;
`endif

  // The timer must be preset on the same edge that enters SETTLE, so the load
  // is decoded from the transitions into SETTLE rather than from the state.
  assign timer_load = accept || ((state == CHECK) && !finish);

  assign {a, b, c} = index;

  settle_timer #(
    .WIDTH      (TIMER_W),
    .LOAD_VALUE (TIMER_W'(SETTLE_CYCLES - 1))
  ) u_settle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (timer_load),
    .tc    (timer_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      index     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_mask <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= SETTLE;
            index     <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_mask <= '0;
          end
        end
        SETTLE: begin
          if (timer_tc) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          err_count <= err_next;
          if (mismatch) begin
            fail_mask[index] <= 1'b1;
          end
          if (finish) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            state <= SETTLE;
            index <= index + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_checker.sv
module tb_vector_checker;

  localparam int S = 2;

  typedef struct {
    int         lat;
    int         err;
    logic [7:0] mask;
    logic       pass;
    logic [2:0] abc;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       y_in;
  logic       a, b, c, busy, done, pass;
  logic [3:0] err_count;
  logic [7:0] fail_mask;

  int   mode = 0;   // 0: correct model, 1: tied low, 2: inverted model
  int   vectors = 0;
  int   miscompares = 0;
  res_t sb[$];

  vector_checker #(
    .EXPECTED      (8'b0011_0001),
    .SETTLE_CYCLES (S)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .y_in      (y_in),
    .a         (a),
    .b         (b),
    .c         (c),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_mask (fail_mask)
  );

  always #5 clk = ~clk;

  function automatic logic silly(input logic [2:0] v);
    return (~v[1] & ~v[0]) | (v[2] & ~v[1]);
  endfunction

  function automatic logic ymodel(input int m, input logic [2:0] v);
    if (m == 1) return 1'b0;
    if (m == 2) return ~silly(v);
    return silly(v);
  endfunction

  always_comb y_in = ymodel(mode, {a, b, c});

  function automatic res_t predict(input int m);
    res_t r;
    bit   stopped;
    r.lat = 0; r.err = 0; r.mask = '0; r.abc = '0;
    stopped = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!stopped) begin
        r.lat += S + 1;
        r.abc = 3'(i);
        if (ymodel(m, 3'(i)) != silly(3'(i))) begin
          r.err++;
          r.mask[i] = 1'b1;
`ifdef VECTOR_CHECKER_STOP_ON_FAIL_EN
          stopped = 1'b1;
`endif
        end
      end
    end
    r.pass = (r.err == 0);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_sweep(input bit extra);
    res_t e;
    int   cyc;
    sb.push_back(predict(mode));
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("accept_busy", 32'(busy), 32'd1);
    chk("accept_done", 32'(done), 32'd0);
    chk("accept_err", 32'(err_count), 32'd0);
    chk("accept_mask", 32'(fail_mask), 32'd0);
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      chk("abc_walk", 32'({a, b, c}), 32'(cyc / (S + 1)));
      @(negedge clk);
      cyc++;
      start = extra && (cyc == 5 || cyc == 12);
    end
    start = 1'b0;
    e = sb.pop_front();
    chk("done_latency", 32'(cyc), 32'(e.lat));
    chk("err_count", 32'(err_count), 32'(e.err));
    chk("fail_mask", 32'(fail_mask), 32'(e.mask));
    chk("pass", 32'(pass), 32'(e.pass));
    chk("busy_after", 32'(busy), 32'd0);
    chk("abc_final", 32'({a, b, c}), 32'(e.abc));
    repeat (2) @(negedge clk);
    chk("done_hold", 32'(done), 32'd1);
    chk("err_hold", 32'(err_count), 32'(e.err));
  endtask

  initial begin
    #12;
    chk("rst_outputs", 32'({a, b, c, busy, done, pass, err_count, fail_mask}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    mode = 0; run_sweep(1'b0);
    mode = 1; run_sweep(1'b0);
    mode = 2; run_sweep(1'b0);
    mode = 0; run_sweep(1'b0);

    // abort mid-sweep
    mode = 1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_abort_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_outputs", 32'({a, b, c, busy, done, pass, err_count, fail_mask}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle", 32'({busy, done}), 32'd0);
    mode = 0; run_sweep(1'b0);

    // spurious starts while busy
    mode = 0; run_sweep(1'b1);
    mode = 1; run_sweep(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vector_checker.md
Name: vector_checker

Overview:
- Hardware self-checking stimulus and response stage that wraps a 3-input, 1-output combinational function (sillyfunction).
- Upstream role: drives the function's a/b/c inputs through all 8 input combinations.
- Downstream role: samples the function's y output and compares it against a parameterised expected truth table.
- Reports an error count, a per-vector fail mask and a pass flag. This is the synthesisable counterpart of the team's simulation-only checks.

Parameters:
- EXPECTED, 8'b0011_0001, expected y per vector; bit i is the expected y for {a,b,c}==i.
- SETTLE_CYCLES, 2, cycles each vector is held before its check cycle (legal range 1..15).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to run the full vector sweep.
- y_in  input  1  output of the function under check.
- a  output  1  function input a (vector bit 2).
- b  output  1  function input b (vector bit 1).
- c  output  1  function input c (vector bit 0).
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until the next accepted start.
- pass  output  1  equals done && (err_count==0).
- err_count  output  4  number of mismatching vectors, range 0..8.
- fail_mask  output  8  bit i set if vector i mismatched.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state goes to IDLE; vector index goes to 0.
  - a/b/c, busy, done, pass, err_count and fail_mask all go to 0.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE: on start==1, at the next edge:
  - state goes to SETTLE, index goes to 0, {a,b,c} goes to 3'b000.
  - err_count and fail_mask clear; busy goes to 1.
- SETTLE:
  - Lasts exactly SETTLE_CYCLES cycles, timed by a down-counter loaded on entry.
  - Goes to CHECK when the counter reaches its terminal count.
- CHECK: one cycle. On its closing edge:
  - y_in is compared to EXPECTED[index].
  - On mismatch: err_count increments and fail_mask[index] is set.
  - If index==7: go to DONE, busy goes to 0, done goes to 1.
  - Otherwise: index increments, {a,b,c} takes the new index, go to SETTLE.
- Each vector is held for SETTLE_CYCLES+1 cycles.
- Latency: done rises 8*(SETTLE_CYCLES+1) cycles after the edge that accepts start. This is 24 cycles at the default.
- {a,b,c} always equals the current index. It is stable throughout SETTLE and CHECK and changes only on the closing edge of CHECK.
- start while busy (SETTLE or CHECK) is ignored and has no side effects.
- DONE:
  - Outputs hold.
  - start is accepted exactly as in IDLE: counters clear, done drops, a new sweep begins.
- y_in is sampled only on CHECK closing edges and is ignored otherwise.
- err_count never exceeds 8, so no saturation logic is needed.
- Reset asserted mid-sweep aborts immediately to reset values. No partial results are retained.

Optional Feature:
- Macro: VECTOR_CHECKER_STOP_ON_FAIL_EN.
- Defined: the first mismatching CHECK goes straight to DONE.
  - err_count==1 and fail_mask has a single bit set.
  - a/b/c hold the failing vector while in DONE.
- Undefined: the full 8-vector sweep always runs to completion.

Decomposition:
- Package vector_checker_pkg:
  - state enum (IDLE, SETTLE, CHECK, DONE), 2 bits.
  - NUM_VECTORS=8.
  - SILLY_EXPECTED=8'b0011_0001 as the default for EXPECTED.
  - Widths: index 3 bits, err_count 4 bits.
- Sub-module settle_timer:
  - Parameterised down-counter with load and terminal-count outputs.
  - Loaded on SETTLE entry; instantiated once.

Test Plan:
1. Correct sillyfunction model on y_in, default parameters, start pulse:
   - done rises after exactly 24 cycles.
   - err_count=0, fail_mask=8'h00, pass=1, busy low after completion.
2. y_in tied to 0:
   - err_count=3, fail_mask=8'h31, pass=0.
   - a/b/c observed stepping through 000..111 with each value held 3 cycles.
3. y_in driven as the inverted model:
   - err_count=8, fail_mask=8'hFF.
   - Then issue start in DONE: done drops the next cycle and counters clear. With the correct model connected, the rerun ends with pass=1.
4. rst_n asserted 10 cycles into a sweep:
   - All outputs are 0 immediately, without waiting for a clock.
   - A later start completes normally in 24 cycles.
5. Extra start pulses at cycles 5 and 12 of a sweep:
   - No restart; done still at cycle 24; results identical to scenario 1.
6. With VECTOR_CHECKER_STOP_ON_FAIL_EN defined and y_in tied to 0:
   - done rises 3 cycles after start.
   - err_count=1, fail_mask=8'h01, {a,b,c}=000.
   - With the correct model connected instead, the behaviour is identical to scenario 1.
